// File: rtl/m_crc16_lane_scheduler.sv
// Lane scheduler for the four SD DAT-line CRC16 engines: collects host bytes,
// splits each 4-byte group into per-lane bytes, strobes the engines and returns their CRCs.
module m_crc16_lane_scheduler #(
    parameter int BLOCK_BYTES   = 512,
    parameter int ENGINE_CYCLES = 5,
    parameter int VALID_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_eng_enable,
    output logic        o_eng_getdata,
    output logic [31:0] o_lane_data,
    input  logic [3:0]  i_eng_valid,
    input  logic [63:0] i_eng_crc,
    output logic [63:0] o_crc_out,
    output logic        o_crc_valid,
    input  logic        i_crc_ack,
    output logic        o_crc_err,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COLLECT    = 3'd1;
    localparam logic [2:0] S_FEED       = 3'd2;
    localparam logic [2:0] S_WAIT       = 3'd3;
    localparam logic [2:0] S_WAIT_VALID = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [15:0] GROUPS       = 16'(BLOCK_BYTES / 4);
    localparam logic [15:0] WAIT_LAST    = 16'(ENGINE_CYCLES - 2);
    localparam logic [15:0] TIMEOUT_LAST = 16'(VALID_TIMEOUT - 1);

    // Nibble k of the group (k=0 is B0 high nibble) supplies bit 7-k of every lane byte.
    function automatic logic [31:0] f_remap(input logic [31:0] asm_word);
        logic [31:0] res;
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                res[8*i + 7 - k] = asm_word[28 - 4*k + i];
            end
        end
        return res;
    endfunction

    logic [2:0]  r_state;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_group_cnt;
    logic [15:0] r_cnt;
    logic [31:0] r_asm;
    logic [31:0] r_lane_data;
    logic [63:0] r_crc_out;
    logic        r_in_ready;
    logic        r_eng_enable;
    logic        r_getdata;
    logic        r_crc_valid;
    logic        r_crc_err;
    logic        r_busy;

    logic [2:0]  w_state_nxt;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_all_valid;
    logic        w_timeout;

    // Next-state decode; abort overrides every transition and never raises an error.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_accept    = (r_state == S_COLLECT) && i_in_valid;
        w_last_byte = w_accept && (r_byte_cnt[1:0] == 2'd3);
        w_all_valid = (i_eng_valid == 4'hF);
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) w_state_nxt = S_COLLECT;
                    else         w_state_nxt = S_IDLE;
                end
                S_COLLECT: begin
                    if (w_last_byte) w_state_nxt = S_FEED;
                    else             w_state_nxt = S_COLLECT;
                end
                S_FEED: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        if (r_group_cnt == GROUPS) w_state_nxt = S_WAIT_VALID;
                        else                       w_state_nxt = S_COLLECT;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT_VALID: begin
                    if (w_all_valid) begin
                        w_state_nxt = S_DONE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_timeout   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_VALID;
                    end
                end
                S_DONE: begin
                    if (i_crc_ack) w_state_nxt = S_IDLE;
                    else           w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register and control outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_eng_enable <= 1'b0;
            r_getdata    <= 1'b0;
            r_crc_valid  <= 1'b0;
            r_crc_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= (w_state_nxt == S_COLLECT);
            r_eng_enable <= (w_state_nxt != S_IDLE);
            r_getdata    <= (w_state_nxt == S_FEED);
            r_crc_valid  <= (w_state_nxt == S_DONE);
            r_crc_err    <= w_timeout;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    // Byte/group counters and the per-state cycle counter (restarts on every state change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= 16'd0;
            r_group_cnt <= 16'd0;
            r_cnt       <= 16'd0;
        end else if (i_abort || (r_state == S_IDLE && i_start)) begin
            r_byte_cnt  <= 16'd0;
            r_group_cnt <= 16'd0;
            r_cnt       <= 16'd0;
        end else begin
            if (w_accept) r_byte_cnt <= r_byte_cnt + 16'd1;
            if (r_state == S_FEED) r_group_cnt <= r_group_cnt + 16'd1;
            if (w_state_nxt != r_state) r_cnt <= 16'd0;
            else                        r_cnt <= r_cnt + 16'd1;
        end
    end

    // Byte assembly and lane data; lane data only moves when a group completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm       <= 32'h0;
            r_lane_data <= 32'h0;
        end else if (i_abort) begin
            r_asm       <= 32'h0;
            r_lane_data <= 32'h0;
        end else begin
            if (w_accept)    r_asm       <= {r_asm[23:0], i_in_data};
            if (w_last_byte) r_lane_data <= f_remap({r_asm[23:0], i_in_data});
        end
    end

    // CRC result latch: captured when all engines report valid, kept until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_out <= 64'h0;
        end else if (i_abort || (r_state == S_IDLE && i_start)) begin
            r_crc_out <= 64'h0;
        end else if (r_state == S_WAIT_VALID && w_all_valid) begin
            r_crc_out <= i_eng_crc;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_eng_enable  = r_eng_enable;
    assign o_eng_getdata = r_getdata;
    assign o_lane_data   = r_lane_data;
    assign o_crc_out     = r_crc_out;
    assign o_crc_valid   = r_crc_valid;
    assign o_crc_err     = r_crc_err;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_m_crc16_lane_scheduler.sv
// Scoreboard bench for m_crc16_lane_scheduler with behavioural CRC16 engines behind it.
module tb_m_crc16_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_in_data = 8'h0;
    logic        i_in_valid = 1'b0;
    logic        i_crc_ack = 1'b0;
    logic [3:0]  i_eng_valid;
    logic [63:0] i_eng_crc;
    logic        o_in_ready, o_eng_enable, o_eng_getdata, o_crc_valid, o_crc_err, o_busy;
    logic [31:0] o_lane_data;
    logic [63:0] o_crc_out;

    m_crc16_lane_scheduler dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .o_eng_enable(o_eng_enable), .o_eng_getdata(o_eng_getdata), .o_lane_data(o_lane_data),
        .i_eng_valid(i_eng_valid), .i_eng_crc(i_eng_crc), .o_crc_out(o_crc_out),
        .o_crc_valid(o_crc_valid), .i_crc_ack(i_crc_ack), .o_crc_err(o_crc_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int gd_count = 0;
    int last_gd = -100;
    logic prev_cv = 1'b0;
    logic [31:0] exp_lane_q[$];
    logic [63:0] exp_crc_q[$];
    logic [7:0]  blk[512];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // CRC16-CCITT, poly 0x1021, MSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int n = 0; n < 8; n++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Lane byte = bit 'lane' of each of the eight nibbles, first nibble as MSB
    function automatic logic [7:0] lane_byte(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3, input int lane);
        logic [7:0] bytes[4];
        logic [3:0] nib;
        logic [7:0] r;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        r = 8'h0;
        for (int k = 0; k < 8; k++) begin
            nib = (k % 2 == 0) ? bytes[k/2][7:4] : bytes[k/2][3:0];
            r = {r[6:0], nib[lane]};
        end
        return r;
    endfunction

    function automatic logic [31:0] lanes_of(input int g);
        logic [31:0] w;
        for (int l = 0; l < 4; l++)
            w[8*l +: 8] = lane_byte(blk[4*g], blk[4*g+1], blk[4*g+2], blk[4*g+3], l);
        return w;
    endfunction

    function automatic logic [63:0] ref_crc();
        logic [63:0] r;
        logic [15:0] c;
        for (int l = 0; l < 4; l++) begin
            c = 16'h0;
            for (int g = 0; g < 128; g++)
                c = crc16_byte(c, lane_byte(blk[4*g], blk[4*g+1], blk[4*g+2], blk[4*g+3], l));
            r[16*l +: 16] = c;
        end
        return r;
    endfunction

    // Behavioural engines: sample lane data two cycles after GetData, report after 128 bytes
    logic [15:0] eng_crc[4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    int   eng_cnt = 0;
    int   eng_dly = 0;
    logic gd1 = 1'b0, gd2 = 1'b0;
    logic [3:0] valid_mask = 4'hF;

    always @(posedge clk) begin
        if (!o_eng_enable) begin
            for (int i = 0; i < 4; i++) eng_crc[i] <= 16'h0;
            eng_cnt <= 0; eng_dly <= 0; gd1 <= 1'b0; gd2 <= 1'b0;
        end else begin
            gd1 <= o_eng_getdata;
            gd2 <= gd1;
            if (gd2) begin
                for (int i = 0; i < 4; i++) eng_crc[i] <= crc16_byte(eng_crc[i], o_lane_data[8*i +: 8]);
                eng_cnt <= eng_cnt + 1;
            end
            if (eng_cnt == 128 && eng_dly < 3) eng_dly <= eng_dly + 1;
        end
    end
    assign i_eng_valid = (eng_dly == 3) ? valid_mask : 4'h0;
    assign i_eng_crc   = {eng_crc[3], eng_crc[2], eng_crc[1], eng_crc[0]};

    // Monitor: pops expectations whenever the DUT strobes lanes or presents a CRC
    initial begin
        forever begin
            @(negedge clk);
            if (!o_eng_enable) gd_count = 0;
            if (o_eng_getdata) begin
                if (gd_count > 0) check("getdata_spacing_ge5", 64'((cyc - last_gd) >= 5), 64'd1);
                last_gd = cyc;
                gd_count++;
                if (exp_lane_q.size() == 0) fail_now("lane_data_unexpected_getdata");
                else check("lane_data", 64'(o_lane_data), 64'(exp_lane_q.pop_front()));
            end
            if (o_crc_valid && !prev_cv) begin
                if (exp_crc_q.size() == 0) fail_now("crc_out_unexpected_valid");
                else check("crc_out", o_crc_out, exp_crc_q.pop_front());
                check("getdata_count", 64'(gd_count), 64'd128);
            end
            prev_cv = o_crc_valid;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(o_in_ready), 64'd0);
        check({tag, "_eng_enable"}, 64'(o_eng_enable), 64'd0);
        check({tag, "_getdata"}, 64'(o_eng_getdata), 64'd0);
        check({tag, "_lane_data"}, 64'(o_lane_data), 64'd0);
        check({tag, "_crc_out"}, o_crc_out, 64'd0);
        check({tag, "_crc_valid"}, 64'(o_crc_valid), 64'd0);
        check({tag, "_crc_err"}, 64'(o_crc_err), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps && $urandom_range(3, 0) == 0) begin
            i_in_valid = 1'b0;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end
        i_in_valid = 1'b1;
        i_in_data  = b;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (o_in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        if (!ok) fail_now("in_ready_timeout");
    endtask

    // mode 0: zeros, 1: known patterns then random, 2: random
    task automatic run_block(input int mode, input bit gaps, input int nbytes, input bit want_crc);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("start_busy", 64'(o_busy), 64'd1);
        check("start_in_ready", 64'(o_in_ready), 64'd1);
        for (int i = 0; i < 512; i++) blk[i] = (mode == 0) ? 8'h00 : 8'($urandom);
        if (mode == 1) begin
            blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h56; blk[3] = 8'h78;
            blk[4] = 8'h80; blk[5] = 8'h00; blk[6] = 8'h00; blk[7] = 8'h00;
            for (int i = 8; i < 12; i++) blk[i] = 8'h0F;
        end
        for (int g = 0; g < nbytes / 4; g++) begin
            for (int j = 0; j < 4; j++) send_byte(blk[4*g + j], gaps);
            if (mode == 1 && g == 0)      exp_lane_q.push_back(32'h011E66AA);
            else if (mode == 1 && g == 1) exp_lane_q.push_back(32'h80000000);
            else if (mode == 1 && g == 2) exp_lane_q.push_back(32'h55555555);
            else                          exp_lane_q.push_back(lanes_of(g));
        end
        if (want_crc) exp_crc_q.push_back(ref_crc());
    endtask

    task automatic finish_block();
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (o_crc_valid) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            fail_now("crc_valid_timeout");
        end else begin
            repeat ($urandom_range(4, 1)) begin
                @(negedge clk);
                check("crc_valid_held", 64'(o_crc_valid), 64'd1);
            end
            @(posedge clk); #1;
            i_crc_ack = 1'b1;
            @(posedge clk); #1;
            i_crc_ack = 1'b0;
            check("ack_crc_valid_low", 64'(o_crc_valid), 64'd0);
            check("ack_eng_enable_low", 64'(o_eng_enable), 64'd0);
            check("ack_busy_low", 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        bit seen;
        int err_cyc;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_block(0, 1'b0, 512, 1'b1);
        finish_block();

        run_block(1, 1'b1, 512, 1'b1);
        finish_block();

        // lane 2 never reports valid
        valid_mask = 4'hB;
        run_block(2, 1'b0, 512, 1'b0);
        seen = 1'b0;
        err_cyc = 0;
        for (int w = 0; w < 80; w++) begin
            @(negedge clk);
            if (o_crc_err) begin seen = 1'b1; err_cyc = cyc; break; end
        end
        if (!seen) begin
            fail_now("crc_err_timeout");
        end else begin
            check("crc_err_delay", 64'(err_cyc - last_gd), 64'd13);
            check("crc_err_busy_low", 64'(o_busy), 64'd0);
            @(negedge clk);
            check("crc_err_one_cycle", 64'(o_crc_err), 64'd0);
            check("crc_err_no_valid", 64'(o_crc_valid), 64'd0);
        end
        valid_mask = 4'hF;
        @(posedge clk); #1;

        // abort mid-block
        run_block(2, 1'b1, 200, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check_idle("abort");
        run_block(2, 1'b1, 512, 1'b1);
        finish_block();

        // reset during WAIT
        run_block(2, 1'b0, 40, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(2, 1'b1, 512, 1'b1);
        finish_block();

        repeat (3) @(posedge clk);
        check("lane_queue_drained", 64'(exp_lane_q.size()), 64'd0);
        check("crc_queue_drained", 64'(exp_crc_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/m_crc16_lane_scheduler.md
# m_crc16_lane_scheduler

Sequencer for the four per-line CRC16 engines of the 4-bit SD data bus. It accepts a block's payload as a host byte stream and splits each group of four bytes into one byte per DAT line. It then strobes all four engines in lock-step, waits for their results and hands the four 16-bit CRCs to the data-path transmitter/checker. It owns the engines' `Enable`/`GetData` timing; engines and the shared four-port CRC table sit directly behind it.

## Interface
- `BLOCK_BYTES`, 512: payload bytes per block; multiple of 4. Each lane gets `BLOCK_BYTES/4` bytes; engines must be built with that string length.
- `ENGINE_CYCLES`, 5: minimum clocks from one `GetData` pulse to the next.
- `VALID_TIMEOUT`, 8: clocks allowed in WAIT_VALID before error.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `Start`  in  1: 1-cycle pulse, begin a block; ignored unless IDLE.
- `Abort`  in  1: level; forces return to IDLE.
- `In_Data`  in  8: payload byte; high nibble goes on the bus first.
- `In_Valid`  in  1: byte present.
- `In_Ready`  out  1: byte accepted when `In_Valid & In_Ready`.
- `Eng_Enable`  out  1: common `Enable` to all four engines.
- `Eng_GetData`  out  1: common `GetData` pulse.
- `Lane_Data`  out  32: lane i byte on bits [8i+7:8i].
- `Eng_Valid`  in  4: engine `Valid` outputs, bit i = lane i.
- `Eng_Crc`  in  64: engine CRCs, lane i on [16i+15:16i].
- `Crc_Out`  out  64: latched CRCs, same packing.
- `Crc_Valid`  out  1: `Crc_Out` valid; held until acked.
- `Crc_Ack`  in  1: consumer accept.
- `Crc_Err`  out  1: 1-cycle pulse on engine timeout.
- `Busy`  out  1: high in every state except IDLE.

## Operation
- Lane mapping: group bytes B0..B3 give nibbles N0=B0[7:4], N1=B0[3:0], ..., N7=B3[3:0]. Lane i byte = {N0[i],N1[i],...,N7[i]}, MSB first.
- States:
  - IDLE: `Eng_Enable`=0, which clears the engines. `Start` → COLLECT and zeroes the group and byte counters.
  - COLLECT: `In_Ready`=1. Each accepted byte shifts into a 32-bit assembly register. On the 4th byte, `Lane_Data` loads from the remapped register → FEED.
  - FEED: `Eng_GetData`=1 for exactly one cycle → WAIT.
  - WAIT: hold `Lane_Data` stable for `ENGINE_CYCLES-1` cycles; group counter +1. Then → WAIT_VALID if the group counter equals `BLOCK_BYTES/4`, else → COLLECT.
  - WAIT_VALID: when `Eng_Valid`==4'hF, latch `Eng_Crc` into `Crc_Out` → DONE. After `VALID_TIMEOUT` cycles without all four valid: pulse `Crc_Err` → IDLE.
  - DONE: `Crc_Valid`=1. `Crc_Ack` → IDLE, which drops `Eng_Enable` for at least one cycle and resets the engines.
- `Eng_Enable` is 1 in all states except IDLE.
- `Abort` has priority over all transitions. It goes to IDLE next cycle, drops `Crc_Valid` and `In_Ready`, and does not pulse `Crc_Err`.
- `Start` in a non-IDLE state is ignored.
- Counters are 16 bits wide and never wrap within a legal block.

## Timing
- Reset values: `In_Ready`=0, `Eng_Enable`=0, `Eng_GetData`=0, `Lane_Data`=0, `Crc_Out`=0, `Crc_Valid`=0, `Crc_Err`=0, `Busy`=0; state IDLE.
- `Start` at cycle t → `Busy`=1 and `In_Ready`=1 at t+1.
- 4th byte accepted at t → `Eng_GetData` high at t+1 → `In_Ready` high again at t+1+`ENGINE_CYCLES`.
- Per-group minimum: 4 + 1 + (`ENGINE_CYCLES`-1) cycles, i.e. 9 with defaults.
- `Lane_Data` changes only on the cycle the 4th byte is accepted. It is held through the engine's index cycle, which is 2 cycles after `GetData`.
- `In_Valid` gaps stall COLLECT indefinitely; there is no timeout there.
- `Crc_Out` is held from DONE until the next `Start`, and is cleared by `Abort`.
- `Crc_Ack` is sampled only in DONE.
- `Crc_Ack` and `Abort` in the same cycle → IDLE; the outcome is the same.

## Test plan
- Lane mapping: bytes 0x12,0x34,0x56,0x78 → `Lane_Data` lanes 0..3 = 0xAA, 0x66, 0x1E, 0x01.
- Bit placement: 0x80,0x00,0x00,0x00 → lane3=0x80, lanes 0–2=0x00. Bytes all 0x0F → every lane 0x55.
- Full block of 512 zero bytes with real engines → `Crc_Valid` with `Crc_Out`=64'h0. Also check exactly 128 `Eng_GetData` pulses, each ≥5 cycles apart.
- Random 512-byte block with random `In_Valid` gaps → `Crc_Out` equals a model CRC16-CCITT (poly 0x1021, init 0) per lane. `Crc_Valid` holds until `Crc_Ack`, then `Eng_Enable`=0 for ≥1 cycle.
- Engine stub that never asserts lane 2 valid → `Crc_Err` one-cycle pulse 8 cycles after entering WAIT_VALID, then IDLE with `Crc_Valid`=0.
- `Abort` mid-block (after 200 bytes) and `rst_n` low mid-WAIT → IDLE next cycle (immediately for reset), all outputs at reset values. A following `Start` produces a correct CRC for a full block.
